smi_frame_arbiter: RTL and testbench

// - Two-input, frame-aware round-robin arbiter that merges two SELF flit streams onto one SELF output.
// - Typical sources are two smiAxiInputBuffer outputs; the sink is a shared SMI transport port.
// - Once an input starts a frame, the grant is held on that input until its end-of-frame flit transfers.

---
 rtl/smi_frame_arbiter.sv | 121 ++++++++++++
 tb/tb_smi_frame_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/smi_frame_arbiter.sv
// smi_frame_arbiter: two-input, frame-aware round-robin arbiter merging two
// SELF flit streams onto one registered SELF output. Once a frame starts on
// an input, that input keeps the grant until its end-of-frame flit transfers.
// Optional build macro: SMI_ARB_FIXED_PRIORITY_EN (A always wins an idle tie).
module smi_frame_arbiter #(
   parameter int unsigned DataWidth = 64
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic                 dataInAValid,
   input  logic [DataWidth-1:0] dataInA,
   input  logic                 dataInAEof,
   output logic                 dataInAStop,
   input  logic                 dataInBValid,
   input  logic [DataWidth-1:0] dataInB,
   input  logic                 dataInBEof,
   output logic                 dataInBStop,
   output logic                 dataOutValid,
   output logic [DataWidth-1:0] dataOut,
   output logic                 dataOutEof,
   output logic                 dataOutSrc,
   input  logic                 dataOutStop
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOCK_A = 2'd1,
      LOCK_B = 2'd2
   } state_t;

   state_t               state;
   logic                 last_grant;   // 0 = A, 1 = B
   logic                 ready_q;
   logic                 out_valid_q;
   logic                 out_eof_q;
   logic                 out_src_q;
   logic [DataWidth-1:0] out_data_q;

   logic                 can_load;
   logic                 grant_a;
   logic                 grant_b;
   logic                 xfer_a;
   logic                 xfer_b;
   logic                 sel_eof;

   // Grant selection: locked states pin the grant, IDLE arbitrates between valid inputs
   always_comb begin
      grant_a = 1'b0;
      grant_b = 1'b0;
      case (state)
         IDLE: begin
            if (dataInAValid && dataInBValid) begin
`ifdef SMI_ARB_FIXED_PRIORITY_EN
               grant_a = 1'b1;
`else
               grant_a = last_grant;
               grant_b = ~last_grant;
`endif
            end else begin
               grant_a = dataInAValid;
               grant_b = dataInBValid;
            end
         end
         LOCK_A:  grant_a = 1'b1;
         LOCK_B:  grant_b = 1'b1;
         default: ;
      endcase
   end

   // Output register can take a flit when empty or being popped this cycle
   assign can_load    = ready_q & (~out_valid_q | ~dataOutStop);
   assign xfer_a      = grant_a & dataInAValid & can_load;
   assign xfer_b      = grant_b & dataInBValid & can_load;
   assign sel_eof     = xfer_a ? dataInAEof : dataInBEof;

   assign dataInAStop = ~(grant_a & can_load);
   assign dataInBStop = ~(grant_b & can_load);

   assign dataOutValid = out_valid_q;
   assign dataOut      = out_data_q;
   assign dataOutEof   = out_eof_q;
   assign dataOutSrc   = out_src_q;

   // Frame-lock FSM, round-robin history and output register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state       <= IDLE;
         last_grant  <= 1'b1;
         ready_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_eof_q   <= 1'b0;
         out_src_q   <= 1'b0;
         out_data_q  <= '0;
      end else begin
         ready_q <= 1'b1;
         if (xfer_a || xfer_b) begin
            out_data_q  <= xfer_a ? dataInA : dataInB;
            out_eof_q   <= sel_eof;
            out_src_q   <= xfer_b;
            out_valid_q <= 1'b1;
            last_grant  <= xfer_b;
            case (state)
               IDLE: begin
                  if (!sel_eof) begin
                     state <= xfer_a ? LOCK_A : LOCK_B;
                  end
               end
               LOCK_A, LOCK_B: begin
                  if (sel_eof) begin
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end else if (!dataOutStop) begin
            out_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_smi_frame_arbiter.sv
// Directed self-checking bench for smi_frame_arbiter.
// Expected orderings switch with SMI_ARB_FIXED_PRIORITY_EN.
module tb_smi_frame_arbiter;

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        dataInAValid, dataInAEof, dataInAStop;
   logic        dataInBValid, dataInBEof, dataInBStop;
   logic [63:0] dataInA, dataInB, dataOut;
   logic        dataOutValid, dataOutEof, dataOutSrc;
   logic        dataOutStop = 1'b0;

   int unsigned n_checks = 0;
   int unsigned n_bad    = 0;

   logic [64:0] qa[$];
   logic [64:0] qb[$];
   logic        en_a = 1'b1;
   logic        en_b = 1'b1;

`ifdef SMI_ARB_FIXED_PRIORITY_EN
   localparam logic [63:0] T2_D [4] = '{64'h11, 64'h12, 64'h21, 64'h22};
   localparam logic [0:3]  T2_S     = 4'b0011;
   localparam logic [63:0] T3_D [3] = '{64'hA3, 64'h31, 64'h32};
   localparam logic [0:2]  T3_S     = 3'b011;
   localparam logic        T3_STOPB = 1'b1;
   localparam logic [63:0] T6_D [5] = '{64'hC0, 64'hC1, 64'hC2, 64'hD0, 64'hD1};
   localparam logic [0:4]  T6_S     = 5'b00011;
`else
   localparam logic [63:0] T2_D [4] = '{64'h11, 64'h21, 64'h12, 64'h22};
   localparam logic [0:3]  T2_S     = 4'b0101;
   localparam logic [63:0] T3_D [3] = '{64'h31, 64'hA3, 64'h32};
   localparam logic [0:2]  T3_S     = 3'b101;
   localparam logic        T3_STOPB = 1'b0;
   localparam logic [63:0] T6_D [5] = '{64'hC0, 64'hD0, 64'hC1, 64'hD1, 64'hC2};
   localparam logic [0:4]  T6_S     = 5'b01010;
`endif

   smi_frame_arbiter #(.DataWidth(64)) dut (
      .clk          (clk),
      .nrst         (nrst),
      .dataInAValid (dataInAValid),
      .dataInA      (dataInA),
      .dataInAEof   (dataInAEof),
      .dataInAStop  (dataInAStop),
      .dataInBValid (dataInBValid),
      .dataInB      (dataInB),
      .dataInBEof   (dataInBEof),
      .dataInBStop  (dataInBStop),
      .dataOutValid (dataOutValid),
      .dataOut      (dataOut),
      .dataOutEof   (dataOutEof),
      .dataOutSrc   (dataOutSrc),
      .dataOutStop  (dataOutStop)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Present queue heads to the DUT as the upstream sources
   task automatic drive();
      dataInAValid = en_a && (qa.size() != 0);
      dataInBValid = en_b && (qb.size() != 0);
      if (dataInAValid) {dataInAEof, dataInA} = qa[0];
      else begin dataInAEof = 1'b0; dataInA = '0; end
      if (dataInBValid) {dataInBEof, dataInB} = qb[0];
      else begin dataInBEof = 1'b0; dataInB = '0; end
   endtask

   task automatic settle();
      drive();
      #1;
   endtask

   // One clock: record which inputs transfer, pass the edge, pop them
   task automatic cycle();
      logic fa, fb;
      settle();
      fa = dataInAValid & ~dataInAStop;
      fb = dataInBValid & ~dataInBStop;
      @(posedge clk);
      #1;
      if (fa) qa.delete(0);
      if (fb) qb.delete(0);
      settle();
   endtask

   task automatic expect_out(input string tag, input logic [63:0] d, input logic src, input logic eof);
      check({tag, ".valid"}, 64'(dataOutValid), 64'd1);
      check({tag, ".data"},  dataOut, d);
      check({tag, ".src"},   64'(dataOutSrc), 64'(src));
      check({tag, ".eof"},   64'(dataOutEof), 64'(eof));
   endtask

   initial begin
      // T1: reset with both inputs valid
      qa.push_back({1'b1, 64'h11}); qa.push_back({1'b1, 64'h12});
      qb.push_back({1'b1, 64'h21}); qb.push_back({1'b1, 64'h22});
      settle();
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("t1_rst_stopa", 64'(dataInAStop), 64'd1);
         check("t1_rst_stopb", 64'(dataInBStop), 64'd1);
         check("t1_rst_valid", 64'(dataOutValid), 64'd0);
      end
      nrst = 1'b1;
      settle();
      check("t1_rel_stopa", 64'(dataInAStop), 64'd1);
      check("t1_rel_stopb", 64'(dataInBStop), 64'd1);
      check("t1_rel_valid", 64'(dataOutValid), 64'd0);
      cycle();
      check("t1_first_stopa", 64'(dataInAStop), 64'd0);
      check("t1_first_stopb", 64'(dataInBStop), 64'd1);
      check("t1_first_valid", 64'(dataOutValid), 64'd0);

      // T2: single-flit frames on both inputs
      for (int i = 0; i < 4; i++) begin
         cycle();
         expect_out($sformatf("t2_%0d", i), T2_D[i], T2_S[i], 1'b1);
      end
      cycle();
      check("t2_drain", 64'(dataOutValid), 64'd0);

      // T3: frame lock with A idle mid-frame, B waiting
      qa.push_back({1'b0, 64'hA0}); qa.push_back({1'b0, 64'hA1});
      qa.push_back({1'b1, 64'hA2}); qa.push_back({1'b1, 64'hA3});
      qb.push_back({1'b1, 64'h31}); qb.push_back({1'b1, 64'h32});
      cycle();
      expect_out("t3_a0", 64'hA0, 1'b0, 1'b0);
      en_a = 1'b0;
      for (int i = 0; i < 2; i++) begin
         settle();
         check("t3_hold_stopb", 64'(dataInBStop), 64'd1);
         cycle();
         check("t3_hold_valid", 64'(dataOutValid), 64'd0);
      end
      en_a = 1'b1;
      cycle();
      expect_out("t3_a1", 64'hA1, 1'b0, 1'b0);
      cycle();
      expect_out("t3_a2", 64'hA2, 1'b0, 1'b1);
      check("t3_after_eof_stopb", 64'(dataInBStop), 64'(T3_STOPB));
      for (int i = 0; i < 3; i++) begin
         cycle();
         expect_out($sformatf("t3_%0d", i), T3_D[i], T3_S[i], 1'b1);
      end
      cycle();
      check("t3_drain", 64'(dataOutValid), 64'd0);

      // T4: downstream backpressure
      qa.push_back({1'b1, 64'h55}); qa.push_back({1'b1, 64'h56});
      cycle();
      expect_out("t4_load", 64'h55, 1'b0, 1'b1);
      dataOutStop = 1'b1;
      for (int i = 0; i < 4; i++) begin
         settle();
         check("t4_stall_stopa", 64'(dataInAStop), 64'd1);
         check("t4_stall_stopb", 64'(dataInBStop), 64'd1);
         cycle();
         expect_out("t4_stall", 64'h55, 1'b0, 1'b1);
      end
      dataOutStop = 1'b0;
      settle();
      check("t4_popload_stopa", 64'(dataInAStop), 64'd0);
      cycle();
      expect_out("t4_next", 64'h56, 1'b0, 1'b1);
      cycle();
      check("t4_drain", 64'(dataOutValid), 64'd0);

      // T5: reset in the middle of an A frame
      en_b = 1'b0;
      qa.push_back({1'b0, 64'hB0}); qa.push_back({1'b1, 64'hB1});
      qb.push_back({1'b1, 64'h77});
      cycle();
      expect_out("t5_b0", 64'hB0, 1'b0, 1'b0);
      en_b = 1'b1;
      nrst = 1'b0;
      qa.delete();
      settle();
      check("t5_rst_valid", 64'(dataOutValid), 64'd0);
      check("t5_rst_stopa", 64'(dataInAStop), 64'd1);
      check("t5_rst_stopb", 64'(dataInBStop), 64'd1);
      cycle();
      check("t5_rst_hold_valid", 64'(dataOutValid), 64'd0);
      nrst = 1'b1;
      settle();
      check("t5_rel_stopb", 64'(dataInBStop), 64'd1);
      cycle();
      check("t5_ready_stopb", 64'(dataInBStop), 64'd0);
      check("t5_ready_stopa", 64'(dataInAStop), 64'd1);
      cycle();
      expect_out("t5_b", 64'h77, 1'b1, 1'b1);
      cycle();
      check("t5_drain", 64'(dataOutValid), 64'd0);

      // T6: continuous single-flit frames on both inputs
      qa.push_back({1'b1, 64'hC0}); qa.push_back({1'b1, 64'hC1}); qa.push_back({1'b1, 64'hC2});
      qb.push_back({1'b1, 64'hD0}); qb.push_back({1'b1, 64'hD1});
      for (int i = 0; i < 5; i++) begin
         cycle();
         expect_out($sformatf("t6_%0d", i), T6_D[i], T6_S[i], 1'b1);
      end
      cycle();
      check("t6_drain", 64'(dataOutValid), 64'd0);

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule
